// File: rtl/aes_pkg.sv
// Shared AES definitions for the vector ALU.
// Contents:
//   valu_op      - forward vector ALU op codes (kept disjoint from the inverse codes)
//   valu_inv_op  - inverse AES op codes handled by valu_inv_aes_unit
//   inv_state_e  - control states of valu_inv_aes_unit
//   INV_SBOX     - AES inverse S-box table
//   gf_xtime     - multiply by x in GF(2^8) mod 0x11B
//   gf_mul2      - two-operand GF(2^8) multiply
//   inv_shift_rows - full-state InvShiftRows, byte i = bits [127-8i -: 8]
package aes_pkg;

  typedef enum logic [3:0] {
    VALU_ADD             = 4'b0000,
    VALU_SUB             = 4'b0001,
    VALU_XOR             = 4'b0010,
    VALU_AES_SUBBYTES    = 4'b0100,
    VALU_AES_SHIFTROWS   = 4'b0101,
    VALU_AES_MIX_COLUMNS = 4'b0110,
    VALU_AES_ROUND       = 4'b1000,
    VALU_AES_ROUND_LAST  = 4'b1001
  } valu_op;

  typedef enum logic [3:0] {
    INV_ROUND_LAST  = 4'b0111,
    INV_SUBBYTES    = 4'b1100,
    INV_SHIFTROWS   = 4'b1101,
    INV_MIX_COLUMNS = 4'b1110,
    INV_ROUND       = 4'b1111
  } valu_inv_op;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } inv_state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant b this reduces to a few XORs.
  function automatic logic [7:0] gf_mul2(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_xtime(p);
    end
    return acc;
  endfunction

  // s'[r][c] = s[r][(c-r) mod 4], with s[r][c] = byte r+4c.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_mixcol.sv
// InvMixColumns on a single 32-bit column (purely combinational).
// Ports:
//   col_in  - column bytes, row 0 in [31:24] .. row 3 in [7:0]
//   col_out - transformed column, same byte order
// Row r output = 0e*b[r] ^ 0b*b[r+1] ^ 0d*b[r+2] ^ 09*b[r+3] (indices mod 4).
module aes_inv_mixcol
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] b [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign b[gi] = col_in[31-8*gi -: 8];
      assign col_out[31-8*gi -: 8] = gf_mul2(b[gi], 8'h0e)
                                   ^ gf_mul2(b[(gi+1)%4], 8'h0b)
                                   ^ gf_mul2(b[(gi+2)%4], 8'h0d)
                                   ^ gf_mul2(b[(gi+3)%4], 8'h09);
    end
  endgenerate

endmodule

// File: rtl/valu_inv_aes_unit.sv
// Multi-cycle AES inverse-transform unit (decrypt side of the vector ALU).
// One request (op, op1 state, op2 round key) is accepted in IDLE; column ops
// then run one 32-bit column per cycle through 4 inverse S-box lanes, the
// round-key XOR and one InvMixColumns column, rewriting the state register.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid / in_ready  - request handshake (in_ready high only in IDLE)
//   op, op1, op2         - op code (valu_inv_op), state, round key
//   out_valid / out_ready- result handshake (out_valid held in DONE)
//   result, err          - transformed state; err flags an unsupported op
module valu_inv_aes_unit
  import aes_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  inv_state_e   state_reg, state_next;
  logic [3:0]   op_reg, op_next;
  logic [127:0] data_reg, data_next;
  logic [127:0] key_reg, key_next;
  logic [1:0]   col_cnt_reg, col_cnt_next;
  logic         err_reg, err_next;

  // Column datapath
  logic [6:0]  col_lsb;
  logic [31:0] cur_col, key_col, sub_col, pre_mix, mix_col, new_col;
  logic        use_sub, use_key, use_mix;

  // Column 0 sits in the top 32 bits, so its LSB is (3 - col_cnt) * 32.
  assign col_lsb = {~col_cnt_reg, 5'b0_0000};
  assign cur_col = data_reg[col_lsb +: 32];
  assign key_col = key_reg[col_lsb +: 32];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      assign sub_col[31-8*gi -: 8] = INV_SBOX[cur_col[31-8*gi -: 8]];
    end
  endgenerate

  // Only column ops reach BUSY, so "not MixColumns" means an S-box op.
  assign use_sub = (op_reg != INV_MIX_COLUMNS);
  assign use_key = (op_reg == INV_ROUND) || (op_reg == INV_ROUND_LAST);
  assign use_mix = (op_reg == INV_ROUND) || (op_reg == INV_MIX_COLUMNS);
  assign pre_mix = (use_sub ? sub_col : cur_col) ^ (use_key ? key_col : 32'h0);

  aes_inv_mixcol u_mixcol (
    .col_in  (pre_mix),
    .col_out (mix_col)
  );

  assign new_col = use_mix ? mix_col : pre_mix;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      op_reg      <= 4'h0;
      data_reg    <= '0;
      key_reg     <= '0;
      col_cnt_reg <= 2'd0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      data_reg    <= data_next;
      key_reg     <= key_next;
      col_cnt_reg <= col_cnt_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    data_next    = data_reg;
    key_next     = key_reg;
    col_cnt_next = col_cnt_reg;
    err_next     = err_reg;
    in_ready     = 1'b0;
    out_valid    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_next      = op;
          key_next     = op2;
          col_cnt_next = 2'd0;
          err_next     = 1'b0;
          case (op)
            INV_SUBBYTES, INV_MIX_COLUMNS: begin
              data_next  = op1;
              state_next = ST_BUSY;
            end
            // Rows are rotated at capture so each BUSY cycle works on a
            // self-contained column.
            INV_ROUND, INV_ROUND_LAST: begin
              data_next  = inv_shift_rows(op1);
              state_next = ST_BUSY;
            end
            INV_SHIFTROWS: begin
              data_next  = inv_shift_rows(op1);
              state_next = ST_DONE;
            end
            default: begin
              data_next  = '0;
              err_next   = 1'b1;
              state_next = ST_DONE;
            end
          endcase
        end
      end
      ST_BUSY: begin
        data_next[col_lsb +: 32] = new_col;
        // Wraps 3 -> 0 on the same edge that leaves BUSY.
        col_cnt_next = col_cnt_reg + 2'd1;
        if (col_cnt_reg == 2'd3) state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign result = data_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_valu_inv_aes_unit.sv
module tb_valu_inv_aes_unit;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [127:0] op1;
  logic [127:0] op2;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] result;
  logic         err;

  logic [31:0]  ref_in;
  logic [31:0]  ref_out;

  int checks;
  int errors;

  valu_inv_aes_unit #(.WIDTH(128)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  aes_inv_mixcol u_ref (
    .col_in  (ref_in),
    .col_out (ref_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request at a negedge, then waits (bounded) for out_valid.
  // Returns at a negedge with the unit in DONE (or after the timeout).
  task automatic send(input logic [3:0] o, input logic [127:0] a, input logic [127:0] b,
                      output int lat);
    @(negedge clk);
    chk("in_ready_before_req", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1;
    op  = o;
    op1 = a;
    op2 = b;
    @(posedge clk);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) break;
    end
    chk("out_valid_timeout", {127'd0, out_valid}, 128'd1);
    chk("in_ready_in_done", {127'd0, in_ready}, 128'd0);
    $display("txn op=%b op1=%h op2=%h result=%h err=%b lat=%0d", o, a, b, result, err, lat);
  endtask

  // Completes the output handshake; result/err must survive it.
  task automatic release_out(input logic [127:0] exp_res, input logic exp_err);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_hs_in_ready", {127'd0, in_ready}, 128'd1);
    chk("idle_after_hs_out_valid", {127'd0, out_valid}, 128'd0);
    chk("result_held_after_hs", result, exp_res);
    chk("err_held_after_hs", {127'd0, err}, {127'd0, exp_err});
  endtask

  logic [127:0] c1_istart, c1_key, c1_round, c1_last, c1_isrow;
  logic [127:0] all63, all01;
  int lat;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 4'h0;
    op1       = '0;
    op2       = '0;
    ref_in    = 32'h0;
    all63     = {16{8'h63}};
    all01     = {16{8'h01}};
    c1_istart = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    c1_key    = 128'h549932d1f08557681093ed9cbe2c974e;
    c1_round  = 128'h54d990a16ba09ab596bbf40ea111702f;
    c1_last   = 128'he9f74eec023020f61bf2ccf2353c21c7;
    c1_isrow  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
    chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
    chk("reset_result", result, 128'd0);
    chk("reset_err", {127'd0, err}, 128'd0);
    rst_n = 1'b1;

    // Golden column reference
    ref_in = 32'h8e4da1bc;
    #1;
    chk("ref_mixcol_8e4da1bc", {96'd0, ref_out}, {96'd0, 32'hdb135345});
    ref_in = 32'h046681e5;
    #1;
    chk("ref_mixcol_046681e5", {96'd0, ref_out}, {96'd0, 32'hd4bf5d30});

    // INV_SUBBYTES
    send(4'b1100, all63, all01, lat);
    chk("subbytes_result", result, 128'd0);
    chk("subbytes_err", {127'd0, err}, 128'd0);
    chk("subbytes_latency", lat, 5);
    release_out(128'd0, 1'b0);

    // INV_SHIFTROWS
    send(4'b1101, 128'h000102030405060708090a0b0c0d0e0f, '0, lat);
    chk("shiftrows_result", result, 128'h000d0a07_04010e0b_0805020f_0c090603);
    chk("shiftrows_latency", lat, 1);
    release_out(128'h000d0a07_04010e0b_0805020f_0c090603, 1'b0);

    send(4'b1101, c1_istart, '0, lat);
    chk("shiftrows_c1", result, c1_isrow);
    release_out(c1_isrow, 1'b0);

    // INV_MIX_COLUMNS
    send(4'b1110, 128'h8e4da1bc_01010101_01010101_01010101, '0, lat);
    chk("mixcol_result", result, 128'hdb135345_01010101_01010101_01010101);
    chk("mixcol_latency", lat, 5);
    release_out(128'hdb135345_01010101_01010101_01010101, 1'b0);

    // INV_ROUND
    send(4'b1111, all63, all01, lat);
    chk("round_result", result, all01);
    chk("round_latency", lat, 5);
    release_out(all01, 1'b0);

    // INV_ROUND_LAST with back-pressure
    send(4'b0111, all63, all01, lat);
    chk("round_last_result", result, all01);
    chk("round_last_latency", lat, 5);
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      op  = 4'b1101;
      op1 = c1_istart;
      @(negedge clk);
      chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_result", result, all01);
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
    end
    in_valid = 1'b0;
    release_out(all01, 1'b0);

    // FIPS-197 C.1 inverse cipher round 1
    send(4'b1111, c1_istart, c1_key, lat);
    chk("c1_round", result, c1_round);
    release_out(c1_round, 1'b0);

    send(4'b0111, c1_istart, c1_key, lat);
    chk("c1_round_last", result, c1_last);
    release_out(c1_last, 1'b0);

    // Unsupported op
    send(4'b0011, c1_istart, c1_key, lat);
    chk("err_result", result, 128'd0);
    chk("err_flag", {127'd0, err}, 128'd1);
    chk("err_latency", lat, 1);
    release_out(128'd0, 1'b1);

    // err clears on the next supported op
    send(4'b1101, 128'h000102030405060708090a0b0c0d0e0f, '0, lat);
    chk("err_cleared", {127'd0, err}, 128'd0);
    release_out(128'h000d0a07_04010e0b_0805020f_0c090603, 1'b0);

    // Reset during BUSY at col_cnt == 2
    @(negedge clk);
    in_valid = 1'b1;
    op  = 4'b1111;
    op1 = c1_istart;
    op2 = c1_key;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy_col_cnt", {126'd0, dut.col_cnt_reg}, 128'd2);
    chk("rst_busy_out_valid", {127'd0, out_valid}, 128'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_mid_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_mid_result", result, 128'd0);
    $display("txn reset mid-operation in_ready=%b out_valid=%b", in_ready, out_valid);

    send(4'b1111, c1_istart, c1_key, lat);
    chk("post_rst_round", result, c1_round);
    chk("post_rst_latency", lat, 5);
    release_out(c1_round, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
